// File: rtl/lsu_mem_responder_pkg.sv
// Shared types for the LSU memory responder: FSM state encoding, wait-counter
// width and the captured request record.
package lsu_mem_resp_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } mem_req_t;

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Request/response handshake bundle between the LSU data port (master) and the
// memory responder (slave).
interface lsu_mem_responder_if;

  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_wren;
  logic [31:0] req_wdata;
  logic [3:0]  req_bmask;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_vld, req_addr, req_wren, req_wdata, req_bmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_vld, req_addr, req_wren, req_wdata, req_bmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_mem_responder_sram_1rw_be.sv
// Single-port word array with per-byte write enables and a registered read port.
// The array is deliberately not reset so contents survive a controller reset.
module sram_1rw_be #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Multi-cycle data memory responder for the LSU: one outstanding request,
// programmable wait states. Define LSU_MEM_RESP_ERR_EN to reject bad addresses.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_vld
// WAIT  | wait states counting down; access fires when counter reaches 0
// RESP  | response held until rsp_rdy
module lsu_mem_responder
  import lsu_mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lsu_mem_responder_if.slave  bus
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  mem_resp_state_e  state;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req_q;
  logic             err_q;
  logic             rsp_vld_q;
  logic             rsp_err_q;
  logic             rd_hit_q;

  mem_req_t         in_req;
  mem_req_t         acc_req;
  logic             in_err;
  logic             acc_err;
  logic             access_go;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      sram_rdata;

  always_comb begin
    in_req = '{addr: bus.req_addr, wren: bus.req_wren,
               wdata: bus.req_wdata, bmask: bus.req_bmask};
  end

`ifdef LSU_MEM_RESP_ERR_EN
  // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
  assign in_err = ((bus.req_addr - BASE_ADDR) >= 32'(DEPTH_WORDS * 4)) ||
                  (bus.req_addr[1:0] != 2'b00);
`else
  assign in_err = 1'b0;
`endif

  // With zero wait states the access happens on the accept edge from the live inputs.
  always_comb begin
    acc_req = req_q;
    acc_err = err_q;
    if (state == IDLE) begin
      acc_req = in_req;
      acc_err = in_err;
    end
  end

  assign access_go = ((state == IDLE) && bus.req_vld && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == '0));
  assign acc_idx   = IDX_W'((acc_req.addr - BASE_ADDR) >> 2);

  sram_1rw_be #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk   (i_clk),
    .en    (access_go && !acc_err && !i_reset),
    .we    (acc_req.wren),
    .be    (acc_req.bmask),
    .idx   (acc_idx),
    .wdata (acc_req.wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      err_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_hit_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_vld) begin
            req_q <= in_req;
            err_q <= in_err;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_vld_q <= 1'b1;
              rsp_err_q <= in_err;
              rd_hit_q  <= !in_req.wren && !in_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_vld_q <= 1'b1;
            rsp_err_q <= err_q;
            rd_hit_q  <= !req_q.wren && !err_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            state     <= IDLE;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rd_hit_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy   = (state == IDLE) && !i_reset;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_err   = rsp_err_q;
  // SRAM read register is not reset, so it only reaches the port for a good read.
  assign bus.rsp_rdata = rd_hit_q ? sram_rdata : 32'h0;

endmodule
